// File: rtl/uart_rx_byte.sv
// uart_rx_byte -- 8N1 asynchronous serial receiver with a one-entry output
// holding register.
//
// The incoming line is passed through a two-flop synchroniser (rx_s). All
// receiver decisions use rx_s only. A falling rx_s in IDLE starts a half-bit
// countdown to the middle of the start bit. Each data bit is then sampled one
// full bit period later, LSB first, followed by the stop bit.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous, active-high reset
//   rx         serial line, idle high, LSB first
//   rx_data    received byte, stable while rx_valid=1
//   rx_valid   byte available, held until accepted
//   rx_ready   consumer accept
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: byte completed while the holding register was full
//   state_dbg  current receiver state (debug observation only)
//
// Handshake: a byte transfers on every posedge where rx_valid & rx_ready are
// both 1. rx_valid never drops without a transfer. rx_data does not change
// while rx_valid=1, except when a new byte loads on the same edge as a
// transfer. rx_ready is ignored while rx_valid=0. The receiver never stalls the
// line. A byte that finds the register full and not being drained is dropped
// and reported on overrun.
module uart_rx_byte #(
  parameter int BAUD_DIV = 1303,
  parameter int HALF_DIV = BAUD_DIV / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic [2:0] state_dbg
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(HALF_DIV - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  logic          sync1_q, sync1_d;
  logic          rx_s_q, rx_s_d;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          fe_q, fe_d;
  logic          ov_q, ov_d;
  logic          cnt_zero;
  logic          load;

  always_comb begin
    sync1_d   = rx;
    rx_s_d    = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    fe_d      = 1'b0;
    ov_d      = 1'b0;
    load      = 1'b0;
    cnt_zero  = (cnt_q == '0);

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = HALF_RELOAD;
        end
      end
      S_START: begin
        if (cnt_zero) begin
          // A line that is high again at mid start bit was only a glitch.
          if (rx_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
            cnt_d     = BAUD_RELOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_zero) begin
          shift_d[bit_idx_q] = rx_s_q;
          cnt_d              = BAUD_RELOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_zero) begin
          if (rx_s_q) begin
            state_d = S_IDLE;
            // The register can take the byte if it is empty or drains now.
            if (!valid_q || rx_ready) begin
              load = 1'b1;
            end else begin
              ov_d = 1'b1;
            end
          end else begin
            fe_d    = 1'b1;
            state_d = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        // Hold off until the line returns high so a break reports only once.
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      rx_s_q    <= rx_s_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = fe_q;
  assign overrun   = ov_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Testbench for uart_rx_byte.
// u_dut runs at a 16-cycle bit period for the directed scenarios. u_dut_tx runs
// at the default 1303-cycle bit period and receives the repeating transmitter
// pattern in parallel.
// Model: every frame the driver sends is turned into an expected completion
// event. The event is scheduled at (pin fall edge + 2 synchroniser cycles +
// half bit + 9 bits), and marked as either a good byte or a framing error. The
// checker applies those events to a one-entry holding register using the
// observed rx_ready, and compares all outputs every cycle.
`timescale 1ns/1ps
module tb_uart_rx_byte;

  localparam int B         = 16;
  localparam int H         = B / 2;
  localparam int B2        = 1303;
  localparam int FRAME_LAT = 2 + H + 9 * B;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, rx, rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun;
  logic [2:0] state_dbg;

  logic       rst2, rx2, rx_ready2;
  logic [7:0] rx_data2;
  logic       rx_valid2, frame_err2, overrun2;
  logic [2:0] state_dbg2;

  uart_rx_byte #(.BAUD_DIV(B)) u_dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun),
    .state_dbg(state_dbg)
  );

  uart_rx_byte u_dut_tx (
    .clk(clk), .rst(rst2), .rx(rx2), .rx_data(rx_data2), .rx_valid(rx_valid2),
    .rx_ready(rx_ready2), .frame_err(frame_err2), .overrun(overrun2),
    .state_dbg(state_dbg2)
  );

  int cyc = 0;
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks = n_checks + 1;
    if (act != exp_v) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int         exp_edge_q[$];
  bit         exp_good_q[$];

  logic       exp_valid = 1'b0;
  logic [7:0] exp_data = 8'h00;
  bit         ev_hit, ev_good;
  logic [7:0] ev_data;
  logic       exp_fe, exp_ov;
  int         fe_seen = 0, ov_seen = 0, rise_cnt = 0, rise_edge = 0, valid_cycles = 0;
  logic [7:0] rise_data = 8'h00;
  logic       prev_valid = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        exp_valid  = 1'b0;
        exp_data   = 8'h00;
        prev_valid = 1'b0;
        exp_q.delete();
        exp_edge_q.delete();
        exp_good_q.delete();
      end else begin
        ev_hit  = 1'b0;
        ev_good = 1'b0;
        ev_data = 8'h00;
        if (exp_edge_q.size() > 0 && exp_edge_q[0] == cyc) begin
          ev_hit  = 1'b1;
          ev_good = exp_good_q.pop_front();
          ev_data = exp_q.pop_front();
          void'(exp_edge_q.pop_front());
        end
        exp_fe = ev_hit && !ev_good;
        exp_ov = 1'b0;
        if (ev_hit && ev_good) begin
          if (!exp_valid || rx_ready) begin
            exp_valid = 1'b1;
            exp_data  = ev_data;
          end else begin
            exp_ov = 1'b1;
          end
        end else if (exp_valid && rx_ready) begin
          exp_valid = 1'b0;
        end

        chk("rx_valid", int'(rx_valid), int'(exp_valid));
        if (exp_valid) chk("rx_data", int'(rx_data), int'(exp_data));
        chk("frame_err", int'(frame_err), int'(exp_fe));
        chk("overrun", int'(overrun), int'(exp_ov));

        if (frame_err) fe_seen = fe_seen + 1;
        if (overrun) ov_seen = ov_seen + 1;
        if (rx_valid) valid_cycles = valid_cycles + 1;
        if (rx_valid && !prev_valid) begin
          rise_cnt  = rise_cnt + 1;
          rise_edge = cyc;
          rise_data = rx_data;
        end
        prev_valid = rx_valid;
      end
    end
  end

  // ---------------- rx_ready driver ----------------
  bit ready_level = 1'b1;
  int ready_pulse_edge = -1;
  initial begin
    rx_ready = 1'b0;
    forever begin
      @(negedge clk);
      rx_ready = ready_level || (cyc + 1 == ready_pulse_edge);
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_b, input bit pulse_rdy,
                            output int k);
    rx = 1'b0;
    k  = cyc + 1;
    exp_edge_q.push_back(k + FRAME_LAT);
    exp_good_q.push_back(stop_b);
    exp_q.push_back(d);
    if (pulse_rdy) ready_pulse_edge = k + FRAME_LAT;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (B) @(negedge clk);
    end
    rx = stop_b;
    repeat (B) @(negedge clk);
    rx = 1'b1;
  endtask

  // Starts a frame and asserts rst asynchronously in the middle of data bit 4.
  task automatic send_with_reset(input logic [7:0] d);
    rx = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (B) @(negedge clk);
    end
    rx = d[4];
    repeat (B / 2) @(negedge clk);
    #2;
    chk("pre_reset_state_data", int'(state_dbg), 2);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", int'(rx_valid), 0);
    chk("async_rst_data", int'(rx_data), 0);
    chk("async_rst_state", int'(state_dbg), 0);
    chk("async_rst_fe", int'(frame_err), 0);
    chk("async_rst_ov", int'(overrun), 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- transmitter pattern on u_dut_tx ----------------
  logic [11:0] pat_bits = 12'hAAB;
  bit pat_done = 1'b0;
  int fe2 = 0, ov2 = 0, rise2_cnt = 0, last_rise2 = 0;
  logic prev2 = 1'b0;

  initial begin
    rst2      = 1'b1;
    rx2       = 1'b1;
    rx_ready2 = 1'b1;
    repeat (3) @(negedge clk);
    rst2 = 1'b0;
    repeat (4) @(negedge clk);
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < 12; b++) begin
        rx2 = pat_bits[b];
        repeat (B2) @(negedge clk);
      end
    end
    rx2 = 1'b1;
    repeat (10) @(negedge clk);
    pat_done = 1'b1;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst2) begin
        if (frame_err2) fe2 = fe2 + 1;
        if (overrun2) ov2 = ov2 + 1;
        if (rx_valid2 && !prev2) begin
          chk("pattern_data", int'(rx_data2), 8'h55);
          if (rise2_cnt > 0) chk("pattern_interval", cyc - last_rise2, 15636);
          last_rise2 = cyc;
          rise2_cnt  = rise2_cnt + 1;
        end
        prev2 = rx_valid2;
      end
    end
  end

  // ---------------- main sequence ----------------
  int k, r0, f0, v0, o0;

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_valid", int'(rx_valid), 0);
    chk("reset_data", int'(rx_data), 0);
    chk("reset_fe", int'(frame_err), 0);
    chk("reset_ov", int'(overrun), 0);
    chk("reset_state", int'(state_dbg), 0);
    rst = 1'b0;
    idle(4);

    // Basic 0xA5, consumer always ready.
    r0 = rise_cnt; f0 = fe_seen; v0 = valid_cycles;
    send_frame(8'hA5, 1'b1, 1'b0, k);
    idle(2 * B);
    chk("basic_rises", rise_cnt - r0, 1);
    chk("basic_latency", rise_edge - k, 154);  // 2 sync + 8 + 9*16
    chk("basic_data", int'(rise_data), 8'hA5);
    chk("basic_valid_cycles", valid_cycles - v0, 1);
    chk("basic_fe", fe_seen - f0, 0);

    // 4-cycle glitch on an idle line.
    r0 = rise_cnt; f0 = fe_seen;
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(2 * B);
    chk("glitch_rises", rise_cnt - r0, 0);
    chk("glitch_fe", fe_seen - f0, 0);
    chk("glitch_state", int'(state_dbg), 0);

    // 0x3C with a low stop bit.
    r0 = rise_cnt; f0 = fe_seen;
    send_frame(8'h3C, 1'b0, 1'b0, k);
    idle(2 * B);
    chk("badstop_fe", fe_seen - f0, 1);
    chk("badstop_rises", rise_cnt - r0, 0);

    // Line held low for 40 bit times, then a good 0x81.
    f0 = fe_seen;
    rx = 1'b0;
    k  = cyc + 1;
    exp_edge_q.push_back(k + FRAME_LAT);
    exp_good_q.push_back(1'b0);
    exp_q.push_back(8'h00);
    idle(40 * B);
    rx = 1'b1;
    idle(2 * B);
    chk("break_fe", fe_seen - f0, 1);
    r0 = rise_cnt;
    send_frame(8'h81, 1'b1, 1'b0, k);
    idle(2 * B);
    chk("after_break_rises", rise_cnt - r0, 1);
    chk("after_break_data", int'(rise_data), 8'h81);

    // Overrun: 0x11 then 0x22 back-to-back with no consumer.
    ready_level = 1'b0;
    idle(4);
    o0 = ov_seen;
    send_frame(8'h11, 1'b1, 1'b0, k);
    send_frame(8'h22, 1'b1, 1'b0, k);
    idle(B);
    chk("overrun_pulses", ov_seen - o0, 1);
    chk("overrun_held_data", int'(rx_data), 8'h11);
    chk("overrun_held_valid", int'(rx_valid), 1);
    ready_pulse_edge = cyc + 2;
    idle(3);
    chk("single_accept_valid", int'(rx_valid), 0);

    // Accept 0x33 on the same edge that 0x44 completes.
    o0 = ov_seen;
    send_frame(8'h33, 1'b1, 1'b0, k);
    send_frame(8'h44, 1'b1, 1'b1, k);
    idle(B);
    chk("swap_data", int'(rx_data), 8'h44);
    chk("swap_valid", int'(rx_valid), 1);
    chk("swap_no_overrun", ov_seen - o0, 0);

    // Reset in the middle of a frame, then a fresh 0xF0.
    send_with_reset(8'h5A);
    idle(2 * B);
    send_frame(8'hF0, 1'b1, 1'b0, k);
    idle(B);
    chk("post_reset_valid", int'(rx_valid), 1);
    chk("post_reset_data", int'(rx_data), 8'hF0);

    // Wait for the transmitter pattern to finish.
    for (int i = 0; i < 80000 && !pat_done; i++) @(negedge clk);
    chk("pattern_done", int'(pat_done), 1);
    chk("pattern_bytes", rise2_cnt, 3);
    chk("pattern_fe", fe2, 0);
    chk("pattern_ov", ov2, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
